// File: rtl/issue_queue.sv
// issue_queue: in-order task queue between decode and the reservation stations;
// the head entry is dispatched once its destination RS reports not busy.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int NUM_RS = 4,
    parameter int TASK_W = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int TW = $clog2(NUM_RS + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENQ_VALID,
    input  logic [TASK_W-1:0] ENQ_TASK,
    input  logic [TW-1:0]     ENQ_RS,
    output logic              ENQ_READY,
    input  logic [NUM_RS-1:0] RS_BUSY,
    input  logic              FLUSH,
    output logic              DISPATCH_VALID,
    output logic [TASK_W-1:0] DISPATCH_TASK,
    output logic [TW-1:0]     dest_RS,
    output logic [CW-1:0]     COUNT,
    output logic              FULL,
    output logic              EMPTY
);
    logic [TASK_W-1:0] task_mem [DEPTH];
    logic [TW-1:0]     tag_mem  [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic [TW-1:0]     head_tag;
    logic              head_busy, enq, deq;

    assign head_tag = tag_mem[head];

    // Only the busy bit of the head's own RS matters; an out-of-range tag reads as busy.
    always_comb begin
        head_busy = 1'b1;
        for (int i = 0; i < NUM_RS; i++)
            if (head_tag == TW'(i + 1)) head_busy = RS_BUSY[i];
    end

    assign COUNT          = count;
    assign FULL           = count == CW'(DEPTH);
    assign EMPTY          = count == '0;
    assign ENQ_READY      = !FULL;
    assign enq            = ENQ_VALID && ENQ_READY && ENQ_RS != '0 && ENQ_RS <= TW'(NUM_RS);
    assign deq            = !EMPTY && !head_busy;
    assign DISPATCH_VALID = deq;
    assign DISPATCH_TASK  = deq ? task_mem[head] : '0;
    assign dest_RS        = deq ? head_tag : '0;

    always_ff @(posedge CLK) begin
        if (enq && !FLUSH) begin
            task_mem[tail] <= ENQ_TASK;
            tag_mem[tail]  <= ENQ_RS;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (FLUSH) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed checks of reset, dispatch, head-of-line blocking,
// full/wrap, simultaneous enqueue+dispatch, flush, invalid tags and async reset.
module tb_issue_queue;
    logic        CLK = 0, RST = 1, ENQ_VALID = 0, FLUSH = 0;
    logic [31:0] ENQ_TASK = 0;
    logic [2:0]  ENQ_RS = 0;
    logic [3:0]  RS_BUSY = 0;
    logic        ENQ_READY, DISPATCH_VALID, FULL, EMPTY;
    logic [31:0] DISPATCH_TASK;
    logic [2:0]  dest_RS;
    logic [3:0]  COUNT;
    int          errors = 0, checks = 0;
    logic [31:0] exp_task [$];
    logic [2:0]  exp_tag  [$];

    issue_queue dut (
        .CLK(CLK), .RST(RST), .ENQ_VALID(ENQ_VALID), .ENQ_TASK(ENQ_TASK), .ENQ_RS(ENQ_RS),
        .ENQ_READY(ENQ_READY), .RS_BUSY(RS_BUSY), .FLUSH(FLUSH),
        .DISPATCH_VALID(DISPATCH_VALID), .DISPATCH_TASK(DISPATCH_TASK), .dest_RS(dest_RS),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] t, input logic [2:0] rs);
        ENQ_VALID = v;
        ENQ_TASK  = t;
        ENQ_RS    = rs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_empty", EMPTY, 1);
        chk("rst_dv", DISPATCH_VALID, 0);
        RST = 0;
        step;
        chk("idle_empty", EMPTY, 1);
        chk("idle_full", FULL, 0);
        chk("idle_count", COUNT, 0);
        chk("idle_ready", ENQ_READY, 1);
        chk("idle_dv", DISPATCH_VALID, 0);
        chk("idle_dest", dest_RS, 0);
        chk("idle_task", DISPATCH_TASK, 0);

        // single pass, no combinational bypass
        drive(1, 32'hA, 2);
        #1;
        chk("sp_nobypass", DISPATCH_VALID, 0);
        step;
        drive(0, 0, 0);
        #1;
        chk("sp_dv", DISPATCH_VALID, 1);
        chk("sp_dest", dest_RS, 2);
        chk("sp_task", DISPATCH_TASK, 32'hA);
        chk("sp_count", COUNT, 1);
        step;
        chk("sp_empty", EMPTY, 1);
        chk("sp_dv_after", DISPATCH_VALID, 0);

        // head-of-line block
        RS_BUSY = 4'b0001;
        drive(1, 32'hA1, 1);
        step;
        drive(1, 32'hB3, 3);
        step;
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hol_dv", DISPATCH_VALID, 0);
            chk("hol_count", COUNT, 2);
            step;
        end
        RS_BUSY = 4'b0000;
        #1;
        chk("hol_a_dest", dest_RS, 1);
        chk("hol_a_task", DISPATCH_TASK, 32'hA1);
        step;
        chk("hol_b_dest", dest_RS, 3);
        chk("hol_b_task", DISPATCH_TASK, 32'hB3);
        step;
        chk("hol_empty", EMPTY, 1);

        // fill while every RS is busy
        RS_BUSY = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + i, 3'(i % 4 + 1));
            exp_task.push_back(32'h100 + i);
            exp_tag.push_back(3'(i % 4 + 1));
            step;
        end
        drive(0, 0, 0);
        #1;
        chk("full_full", FULL, 1);
        chk("full_ready", ENQ_READY, 0);
        chk("full_count", COUNT, 8);
        drive(1, 32'h999, 1);
        step;
        drive(0, 0, 0);
        #1;
        chk("full_9th_count", COUNT, 8);

        // drain with three more enqueues interleaved
        RS_BUSY = 4'b0000;
        begin
            int rem = 3, done = 0, sz;
            for (int c = 0; c < 40 && (exp_task.size() != 0 || rem != 0); c++) begin
                sz = exp_task.size();
                #1;
                chk("drain_count", COUNT, sz);
                chk("drain_dv", DISPATCH_VALID, sz != 0);
                if (sz != 0) begin
                    chk("drain_task", DISPATCH_TASK, exp_task.pop_front());
                    chk("drain_dest", dest_RS, exp_tag.pop_front());
                    done++;
                end
                if (rem != 0 && sz < 8) begin
                    drive(1, 32'h200 + 3 - rem, 3'((3 - rem) % 4 + 1));
                    exp_task.push_back(32'h200 + 3 - rem);
                    exp_tag.push_back(3'((3 - rem) % 4 + 1));
                    rem--;
                end else drive(0, 0, 0);
                step;
            end
            drive(0, 0, 0);
            chk("drain_total", done, 11);
            chk("drain_left", exp_task.size(), 0);
            #1;
            chk("drain_empty", EMPTY, 1);
            chk("drain_count0", COUNT, 0);
        end

        // simultaneous enqueue and dispatch at COUNT=1
        drive(1, 32'hC4, 4);
        step;
        drive(1, 32'hD1, 1);
        #1;
        chk("sim_c_dest", dest_RS, 4);
        chk("sim_c_task", DISPATCH_TASK, 32'hC4);
        step;
        drive(0, 0, 0);
        #1;
        chk("sim_count", COUNT, 1);
        chk("sim_d_dest", dest_RS, 1);
        chk("sim_d_task", DISPATCH_TASK, 32'hD1);
        step;
        chk("sim_empty", EMPTY, 1);

        // flush beats a same-cycle enqueue
        RS_BUSY = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h300 + i, 2);
            step;
        end
        #1;
        chk("fl_count5", COUNT, 5);
        drive(1, 32'h3FF, 1);
        FLUSH = 1;
        step;
        FLUSH = 0;
        drive(0, 0, 0);
        #1;
        chk("fl_count", COUNT, 0);
        chk("fl_empty", EMPTY, 1);
        chk("fl_dv", DISPATCH_VALID, 0);

        // invalid and out-of-range tags are dropped
        drive(1, 32'h400, 0);
        step;
        chk("inv0_count", COUNT, 0);
        drive(1, 32'h401, 5);
        step;
        drive(0, 0, 0);
        #1;
        chk("inv5_count", COUNT, 0);

        // async reset between edges
        drive(1, 32'h500, 1);
        step;
        drive(0, 0, 0);
        #1;
        chk("ar_count1", COUNT, 1);
        RST = 1;
        #1;
        chk("ar_count", COUNT, 0);
        chk("ar_empty", EMPTY, 1);
        RST = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
